// File: rtl/fft_frame_packer.sv
// Packs strobed PCM samples into framed AXI-stream beats {16'h0, sample} with TLAST
// on the last beat of every FRAME_LEN-sample frame, buffered through a sample FIFO.
module fft_frame_packer #(
  parameter int unsigned FRAME_LEN  = 1024,
  parameter int unsigned FIFO_DEPTH = 2048
) (
  input  logic        I_CLOCK,
  input  logic        I_RESETN,
  input  logic        I_ENABLE,
  input  logic        I_SAMPLE_VALID,
  input  logic [15:0] I_SAMPLE,
  output logic        M_O_DATA_VALID,
  input  logic        M_I_DATA_READY,
  output logic [31:0] M_O_DATA,
  output logic        M_O_DATA_TLAST,
  input  logic        I_CLEAR_OVF,
  output logic        O_OVERFLOW,
  output logic [15:0] O_FRAMES_SENT
);

  localparam int unsigned PtrW = $clog2(FIFO_DEPTH);
  localparam int unsigned CntW = PtrW + 1;
  localparam int unsigned FrmW = $clog2(FRAME_LEN);
  localparam logic [FrmW-1:0] LastIdx = FrmW'(FRAME_LEN - 1);
  localparam logic [CntW-1:0] FullCnt = CntW'(FIFO_DEPTH);

  typedef enum logic [0:0] {StEmpty = 1'b0, StFull = 1'b1} state_e;

  logic [15:0]     mem [FIFO_DEPTH];
  logic [PtrW-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [CntW-1:0] count_q, count_d;
  logic [FrmW-1:0] in_cnt_q, in_cnt_d, out_cnt_q, out_cnt_d;
  state_e          state_q, state_d;
  logic [15:0]     slot_data_q, slot_data_d;
  logic            slot_last_q, slot_last_d;
  logic            overflow_q, overflow_d;
  logic [15:0]     frames_q, frames_d;

  logic gated, fifo_full, fifo_empty, push, pop, handshake;

  function automatic logic [FrmW-1:0] frm_inc(input logic [FrmW-1:0] v);
    return (v == LastIdx) ? '0 : v + FrmW'(1);
  endfunction

  always_comb begin
    // Enable is only honoured at a frame boundary so started frames always complete.
    gated      = I_SAMPLE_VALID && ((in_cnt_q != '0) || I_ENABLE);
    fifo_full  = (count_q == FullCnt);
    fifo_empty = (count_q == '0);
    push       = gated && !fifo_full;
    handshake  = (state_q == StFull) && M_I_DATA_READY;
    pop        = !fifo_empty && ((state_q == StEmpty) || handshake);
  end

  always_comb begin
    wr_ptr_d   = push ? wr_ptr_q + PtrW'(1) : wr_ptr_q;
    rd_ptr_d   = pop ? rd_ptr_q + PtrW'(1) : rd_ptr_q;
    count_d    = count_q;
    unique case ({push, pop})
      2'b10:   count_d = count_q + CntW'(1);
      2'b01:   count_d = count_q - CntW'(1);
      default: count_d = count_q;
    endcase
    in_cnt_d   = gated ? frm_inc(in_cnt_q) : in_cnt_q;
    out_cnt_d  = handshake ? frm_inc(out_cnt_q) : out_cnt_q;
    overflow_d = (overflow_q && !I_CLEAR_OVF) || (gated && fifo_full);
    frames_d   = (handshake && slot_last_q) ? frames_q + 16'd1 : frames_q;
  end

  // Output slot FSM; a loaded word's TLAST is decided by the beat index it will occupy.
  always_comb begin
    state_d     = state_q;
    slot_data_d = slot_data_q;
    slot_last_d = slot_last_q;
    unique case (state_q)
      StEmpty: begin
        if (pop) begin
          state_d     = StFull;
          slot_data_d = mem[rd_ptr_q];
          slot_last_d = (out_cnt_d == LastIdx);
        end
      end
      StFull: begin
        if (handshake) begin
          if (pop) begin
            slot_data_d = mem[rd_ptr_q];
            slot_last_d = (out_cnt_d == LastIdx);
          end else begin
            state_d     = StEmpty;
            slot_last_d = 1'b0;
          end
        end
      end
    endcase
  end

  always_ff @(posedge I_CLOCK) begin
    if (push) begin
      mem[wr_ptr_q] <= I_SAMPLE;
    end
  end

  always_ff @(posedge I_CLOCK or negedge I_RESETN) begin
    if (!I_RESETN) begin
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      count_q     <= '0;
      in_cnt_q    <= '0;
      out_cnt_q   <= '0;
      state_q     <= StEmpty;
      slot_data_q <= '0;
      slot_last_q <= 1'b0;
      overflow_q  <= 1'b0;
      frames_q    <= '0;
    end else begin
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      count_q     <= count_d;
      in_cnt_q    <= in_cnt_d;
      out_cnt_q   <= out_cnt_d;
      state_q     <= state_d;
      slot_data_q <= slot_data_d;
      slot_last_q <= slot_last_d;
      overflow_q  <= overflow_d;
      frames_q    <= frames_d;
    end
  end

  always_comb begin
    M_O_DATA_VALID = (state_q == StFull);
    M_O_DATA       = {16'h0000, slot_data_q};
    M_O_DATA_TLAST = slot_last_q && (state_q == StFull);
    O_OVERFLOW     = overflow_q;
    O_FRAMES_SENT  = frames_q;
  end

endmodule

// File: tb/tb_fft_frame_packer.sv
// Self-checking bench for fft_frame_packer: vector table plus scoreboard of expected beats.
module tb_fft_frame_packer;

  localparam int unsigned FL = 8;
  localparam int unsigned FD = 8;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        enable, sample_valid, ready, clear_ovf;
  logic [15:0] sample;
  logic        valid, tlast, overflow;
  logic [31:0] data;
  logic [15:0] frames;

  fft_frame_packer #(.FRAME_LEN(FL), .FIFO_DEPTH(FD)) dut (
    .I_CLOCK        (clk),
    .I_RESETN       (rst_n),
    .I_ENABLE       (enable),
    .I_SAMPLE_VALID (sample_valid),
    .I_SAMPLE       (sample),
    .M_O_DATA_VALID (valid),
    .M_I_DATA_READY (ready),
    .M_O_DATA       (data),
    .M_O_DATA_TLAST (tlast),
    .I_CLEAR_OVF    (clear_ovf),
    .O_OVERFLOW     (overflow),
    .O_FRAMES_SENT  (frames)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [15:0] sample;
    logic [31:0] exp_data;
    logic        exp_last;
  } vec_t;

  vec_t        tbl [FL];
  logic [32:0] exp_q [$];
  int          total = 0;
  int          bad = 0;
  int          in_idx = 0;
  int          exp_frames = 0;
  bit          mon_en = 1'b0;
  bit          prev_stall = 1'b0;
  logic [32:0] prev_word;

  task automatic check(input string name, input logic [32:0] act, input logic [32:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic [15:0] s);
    sample       = s;
    sample_valid = 1'b1;
    tick();
    sample_valid = 1'b0;
  endtask

  task automatic send(input logic [15:0] s);
    logic last;
    last = (in_idx == FL - 1);
    exp_q.push_back({last, 16'h0000, s});
    if (last) exp_frames++;
    in_idx = (in_idx + 1) % FL;
    drive(s);
  endtask

  // Strobe expected to be dropped by a full FIFO: consumes an input slot, produces no beat.
  task automatic drop(input logic [15:0] s);
    in_idx = (in_idx + 1) % FL;
    drive(s);
  endtask

  task automatic wait_drain(input string name);
    for (int k = 0; k < 300 && exp_q.size() != 0; k++) tick();
    total++;
    if (exp_q.size() != 0) begin
      bad++;
      $display("FAIL %s: got %0d beats pending expected 0", name, exp_q.size());
    end
    tick();
    tick();
  endtask

  task automatic do_reset();
    mon_en = 1'b0;
    rst_n  = 1'b0;
    exp_q.delete();
    in_idx     = 0;
    exp_frames = 0;
    tick();
    tick();
    rst_n = 1'b1;
    tick();
    mon_en = 1'b1;
  endtask

  always @(negedge clk) begin
    if (!mon_en) begin
      prev_stall = 1'b0;
    end else begin
      if (prev_stall) begin
        check("hold_valid", {32'h0, valid}, 33'h1);
        check("hold_data", {tlast, data}, prev_word);
      end
      if (valid && ready) begin
        if (exp_q.size() == 0) begin
          total++;
          bad++;
          $display("FAIL unexpected_beat: got data %h expected no beat", data);
        end else begin
          logic [32:0] e;
          e = exp_q.pop_front();
          check("beat_data", {1'b0, data}, {1'b0, e[31:0]});
          check("beat_last", {32'h0, tlast}, {32'h0, e[32]});
        end
      end
      prev_stall = valid && !ready;
      prev_word  = {tlast, data};
    end
  end

  initial begin
    for (int i = 0; i < FL; i++) begin
      tbl[i].sample   = 16'(i + 1);
      tbl[i].exp_data = 32'(i + 1);
      tbl[i].exp_last = (i == FL - 1);
    end
    rst_n = 1'b0; enable = 1'b0; sample_valid = 1'b0; sample = '0;
    ready = 1'b0; clear_ovf = 1'b0;
    #12;
    check("rst_valid", {32'h0, valid}, 33'h0);
    check("rst_data", {1'b0, data}, 33'h0);
    check("rst_tlast", {32'h0, tlast}, 33'h0);
    check("rst_ovf", {32'h0, overflow}, 33'h0);
    check("rst_frames", {17'h0, frames}, 33'h0);
    do_reset();

    // Basic frame, one strobe every 4 cycles, plus first-beat latency.
    enable = 1'b1;
    ready  = 1'b1;
    for (int i = 0; i < FL; i++) begin
      exp_q.push_back({tbl[i].exp_last, tbl[i].exp_data});
      if (tbl[i].exp_last) exp_frames++;
      in_idx = (in_idx + 1) % FL;
      drive(tbl[i].sample);
      if (i == 0) begin
        @(negedge clk);
        check("lat_valid_n", {32'h0, valid}, 33'h0);
        @(negedge clk);
        check("lat_valid_n1", {32'h0, valid}, 33'h1);
        tick();
        tick();
      end else begin
        tick(); tick(); tick();
      end
    end
    wait_drain("drain_basic");
    check("frames_basic", {17'h0, frames}, 33'(exp_frames));

    // Long stall mid-frame, then random READY over three frames.
    ready = 1'b0;
    for (int i = 0; i < 4; i++) send(16'h0100 + 16'(i));
    for (int i = 0; i < 20; i++) tick();
    check("stall_valid", {32'h0, valid}, 33'h1);
    ready = 1'b1;
    for (int i = 4; i < FL; i++) send(16'h0100 + 16'(i));
    wait_drain("drain_stall");
    begin
      int sent;
      sent = 0;
      while (sent < 3 * FL) begin
        ready = 1'($urandom_range(0, 1));
        if (exp_q.size() < 8 && $urandom_range(0, 1) == 1) begin
          send(16'h0200 + 16'(sent));
          sent++;
        end else begin
          tick();
        end
      end
    end
    ready = 1'b1;
    wait_drain("drain_random");
    check("frames_random", {17'h0, frames}, 33'(exp_frames));

    // Enable dropped mid-frame: the frame completes, then strobes are ignored.
    enable = 1'b1;
    for (int i = 0; i < 3; i++) send(16'h0400 + 16'(i));
    enable = 1'b0;
    for (int i = 3; i < FL; i++) send(16'h0400 + 16'(i));
    for (int i = 0; i < 5; i++) drive(16'h0BAD);
    for (int i = 0; i < 10; i++) tick();
    wait_drain("drain_gate");
    check("frames_gate", {17'h0, frames}, 33'(exp_frames));
    check("ovf_gate", {32'h0, overflow}, 33'h0);

    // Asynchronous reset while a beat is stalled on the output.
    enable = 1'b1;
    ready  = 1'b0;
    for (int i = 0; i < 3; i++) send(16'h0500 + 16'(i));
    tick();
    check("pre_rst_valid", {32'h0, valid}, 33'h1);
    mon_en = 1'b0;
    #2 rst_n = 1'b0;
    #1;
    check("arst_valid", {32'h0, valid}, 33'h0);
    check("arst_data", {1'b0, data}, 33'h0);
    check("arst_tlast", {32'h0, tlast}, 33'h0);
    check("arst_frames", {17'h0, frames}, 33'h0);
    exp_q.delete();
    in_idx = 0;
    exp_frames = 0;
    tick();
    rst_n = 1'b1;
    tick();
    mon_en = 1'b1;
    ready  = 1'b1;
    for (int i = 0; i < FL; i++) begin
      send(16'h0600 + 16'(i));
      tick();
    end
    wait_drain("drain_post_rst");
    check("frames_post_rst", {17'h0, frames}, 33'h1);

    // Overflow with READY low: 1 in slot + FD in FIFO, the next one dropped.
    do_reset();
    enable = 1'b1;
    ready  = 1'b0;
    for (int i = 0; i < FD + 1; i++) send(16'h0300 + 16'(i));
    check("ovf_before", {32'h0, overflow}, 33'h0);
    drop(16'h03FF);
    check("ovf_set", {32'h0, overflow}, 33'h1);
    clear_ovf = 1'b1;
    drop(16'h03FE);
    clear_ovf = 1'b0;
    check("ovf_clear_vs_set", {32'h0, overflow}, 33'h1);
    clear_ovf = 1'b1;
    tick();
    clear_ovf = 1'b0;
    check("ovf_cleared", {32'h0, overflow}, 33'h0);
    ready = 1'b1;
    wait_drain("drain_ovf");
    check("frames_ovf", {17'h0, frames}, 33'(exp_frames));

    // Full FIFO: pop and push in the same cycle, push must still be rejected.
    do_reset();
    enable = 1'b1;
    ready  = 1'b0;
    for (int i = 0; i < FD + 1; i++) send(16'h0700 + 16'(i));
    tick();
    tick();
    ready = 1'b1;
    drop(16'h07EE);
    check("ovf_pop_push", {32'h0, overflow}, 33'h1);
    wait_drain("drain_pop_push");
    check("frames_pop_push", {17'h0, frames}, 33'(exp_frames));

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
